// File: rtl/sr_deserializer.sv
// Serial-to-parallel receiver: shifts accepted serial bits into an N-bit word (MSB- or LSB-first)
// and hands completed words downstream through a single holding register with valid/ready.
module sr_deserializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         msb_first,
    input  logic         sync,
    input  logic         ovr_clr,
    output logic [N-1:0] Q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun,
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [N-1:0]   sr_r, sr_s;
    logic           mode_r, mode_s;
    logic [N-1:0]   q_r, q_s;
    logic           valid_r, valid_s;
    logic           ovr_r, ovr_s;
    logic           busy_r, busy_s;

    logic           mode_eff_s;
    logic [N-1:0]   base_s;
    logic [N-1:0]   shift_s;
    logic           free_s;
    logic           done_s;
    logic           ovr_set_s;

    // Next-state, shift datapath, holding-register and overrun logic
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sr_s      = sr_r;
        mode_s    = mode_r;
        q_s       = q_r;
        done_s    = 1'b0;
        ovr_set_s = 1'b0;

        // A word starting on this edge (from IDLE or via sync) uses the live msb_first
        mode_eff_s = ((state_r == IDLE) || sync) ? msb_first : mode_r;
        base_s     = sync ? {N{1'b0}} : sr_r;
        shift_s    = mode_eff_s ? {base_s[N-2:0], sin} : {sin, base_s[N-1:1]};
        free_s     = (!valid_r) || out_ready;

        if (valid_r && out_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        case (state_r)
            IDLE: begin
                if (sin_valid) begin
                    state_s = SHIFT;
                    cnt_s   = CNT_ONE;
                    sr_s    = shift_s;
                    mode_s  = msb_first;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (sync) begin
                    if (sin_valid) begin
                        state_s = SHIFT;
                        cnt_s   = CNT_ONE;
                        sr_s    = shift_s;
                        mode_s  = msb_first;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                        sr_s    = {N{1'b0}};
                    end
                end else if (sin_valid) begin
                    if (cnt_r == CNT_LAST) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                        sr_s    = shift_s;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                        sr_s    = shift_s;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // A completed word either lands in the holding register or is dropped as an overrun
        if (done_s) begin
            if (free_s) begin
                q_s     = shift_s;
                valid_s = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else begin
            q_s = q_r;
        end

        if (ovr_set_s) begin
            ovr_s = 1'b1;
        end else if (ovr_clr) begin
            ovr_s = 1'b0;
        end else begin
            ovr_s = ovr_r;
        end

        busy_s = (cnt_s != CNT_ZERO);
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            sr_r    <= {N{1'b0}};
            mode_r  <= 1'b0;
            q_r     <= {N{1'b0}};
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sr_r    <= sr_s;
            mode_r  <= mode_s;
            q_r     <= q_s;
            valid_r <= valid_s;
            ovr_r   <= ovr_s;
            busy_r  <= busy_s;
        end
    end

    assign Q         = q_r;
    assign out_valid = valid_r;
    assign overrun   = ovr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sr_deserializer.sv
// Testbench for sr_deserializer: directed scenarios plus randomized traffic checked against
// a bit-queue reference model of the receiver.
module tb_sr_deserializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clear, sin, sin_valid, msb_first, sync, ovr_clr, out_ready;
    logic [N-1:0] Q;
    logic         out_valid, overrun, busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit           mbits[$];
    bit           mmode;
    logic [N-1:0] mq;
    bit           mv;
    bit           movr;

    always #5 clk = ~clk;

    sr_deserializer #(.N(N)) dut (
        .clk       (clk),
        .clear     (clear),
        .sin       (sin),
        .sin_valid (sin_valid),
        .msb_first (msb_first),
        .sync      (sync),
        .ovr_clr   (ovr_clr),
        .Q         (Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    function automatic logic [N-1:0] assemble();
        int word = 0;
        for (int i = 0; i < N; i++) begin
            if (mbits[i]) begin
                if (mmode) word = word + (1 << (N - 1 - i));
                else       word = word + (1 << i);
            end
        end
        return word[N-1:0];
    endfunction

    // Advance the model by one edge using the current inputs, then step the DUT past the edge
    task automatic tick();
        bit           set_ovr = 1'b0;
        logic [N-1:0] w;
        if (!clear) begin
            mbits.delete();
            mq   = '0;
            mv   = 1'b0;
            movr = 1'b0;
        end else begin
            if (mv && out_ready) mv = 1'b0;
            if (sync) mbits.delete();
            if (sin_valid) begin
                if (mbits.size() == 0) mmode = msb_first;
                mbits.push_back(sin);
                if (mbits.size() == N) begin
                    w = assemble();
                    mbits.delete();
                    if (!mv) begin
                        mq = w;
                        mv = 1'b1;
                    end else begin
                        set_ovr = 1'b1;
                    end
                end
            end
            if (set_ovr)      movr = 1'b1;
            else if (ovr_clr) movr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] stream);
        for (int i = N - 1; i >= 0; i--) begin
            sin       = stream[i];
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        tick();
        tick();
        checks++; if (Q !== 8'h00)        begin failures++; $display("FAIL reset_q: got %h expected 00", Q); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        clear = 1'b1;
    endtask

    task automatic test_msb();
        logic [N-1:0] stream = 8'b1100_0101;
        out_ready = 1'b1;
        msb_first = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            sin = stream[i]; sin_valid = 1'b1;
            tick();
            if (i == 1) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL msb_early_valid: got %b expected 0", out_valid); end
            end
        end
        sin_valid = 1'b0;
        checks++; if (Q !== 8'hC5)        begin failures++; $display("FAIL msb_q: got %h expected c5", Q); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL msb_valid: got %b expected 1", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL msb_valid_pulse: got %b expected 0", out_valid); end
    endtask

    task automatic test_lsb();
        logic [N-1:0] stream = 8'b1100_0101;
        out_ready = 1'b1;
        msb_first = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            sin = stream[i]; sin_valid = 1'b1;
            tick();
            if (i == N - 3) msb_first = 1'b1;
        end
        sin_valid = 1'b0;
        checks++; if (Q !== 8'hA3)        begin failures++; $display("FAIL lsb_q: got %h expected a3", Q); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid: got %b expected 1", out_valid); end
        tick();
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        msb_first = 1'b1;
        send_word(8'h12);
        checks++; if (Q !== 8'h12 || out_valid !== 1'b1) begin failures++; $display("FAIL ovr_first: got q=%h v=%b expected q=12 v=1", Q, out_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early: got %b expected 0", overrun); end
        send_word(8'h34);
        checks++; if (Q !== 8'h12 || out_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold: got q=%h v=%b expected q=12 v=1", Q, out_valid); end
        checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ovr_set: got ovr=%b busy=%b expected ovr=1 busy=0", overrun, busy); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr: got %b expected 0", overrun); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] stream = 8'h34;
        out_ready = 1'b0;
        msb_first = 1'b1;
        send_word(8'h12);
        for (int i = N - 1; i >= 0; i--) begin
            sin = stream[i]; sin_valid = 1'b1;
            out_ready = (i == 0);
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_gap: bit %0d got %b expected 1", i, out_valid); end
        end
        sin_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (Q !== 8'h34)      begin failures++; $display("FAIL b2b_q: got %h expected 34", Q); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_sync();
        logic [N-1:0] stream = 8'h9B;
        out_ready = 1'b1;
        msb_first = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sin = i[0]; sin_valid = 1'b1;
            tick();
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sync_busy_pre: got %b expected 1", busy); end
        end
        sync = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            sin = stream[i]; sin_valid = 1'b1;
            tick();
            sync = 1'b0;
            if (i > 0) begin
                checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL sync_busy: bit %0d got busy=%b v=%b expected 1/0", i, busy, out_valid); end
            end
        end
        sin_valid = 1'b0;
        checks++; if (Q !== 8'h9B || out_valid !== 1'b1) begin failures++; $display("FAIL sync_q: got q=%h v=%b expected q=9b v=1", Q, out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sync_busy_end: got %b expected 0", busy); end
        tick();
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b0;
        msb_first = 1'b1;
        send_word(8'h5A);
        for (int i = 0; i < 3; i++) begin
            sin = 1'b1; sin_valid = 1'b1;
            tick();
        end
        clear = 1'b0;
        tick();
        clear = 1'b1;
        sin_valid = 1'b0;
        checks++; if (Q !== 8'h00 || out_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset: got q=%h v=%b ovr=%b busy=%b expected all 0", Q, out_valid, overrun, busy);
        end
        out_ready = 1'b1;
        send_word(8'h3C);
        checks++; if (Q !== 8'h3C || out_valid !== 1'b1) begin failures++; $display("FAIL midreset_word: got q=%h v=%b expected q=3c v=1", Q, out_valid); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            clear     = ($urandom_range(0, 199) != 0);
            sin       = $urandom_range(0, 1);
            sin_valid = ($urandom_range(0, 3) != 0);
            msb_first = $urandom_range(0, 1);
            sync      = ($urandom_range(0, 19) == 0);
            ovr_clr   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
            checks++; if (out_valid !== mv) begin failures++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", c, out_valid, mv); end
            checks++; if (overrun !== movr) begin failures++; $display("FAIL rnd_overrun: cycle %0d got %b expected %b", c, overrun, movr); end
            checks++; if (busy !== (mbits.size() != 0)) begin failures++; $display("FAIL rnd_busy: cycle %0d got %b expected %b", c, busy, (mbits.size() != 0)); end
            if (mv) begin
                checks++; if (Q !== mq) begin failures++; $display("FAIL rnd_q: cycle %0d got %h expected %h", c, Q, mq); end
            end
        end
        clear = 1'b1; sin_valid = 1'b0; sync = 1'b0; ovr_clr = 1'b0;
    endtask

    initial begin
        clear = 1'b1; sin = 1'b0; sin_valid = 1'b0; msb_first = 1'b1;
        sync = 1'b0; ovr_clr = 1'b0; out_ready = 1'b0;
        mmode = 1'b1; mq = '0; mv = 1'b0; movr = 1'b0;
        test_reset();
        test_msb();
        test_lsb();
        test_overrun();
        test_back_to_back();
        test_sync();
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
